aes_mixcolumns_iter: RTL and testbench

AES_MIXCOLUMNS_ITER -- requirements
Module: aes_mixcolumns_iter

---
 rtl/aes_mixcolumns_iter.sv | 157 +++++++++++++++
 tb/tb_aes_mixcolumns_iter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mixcolumns_iter.sv
// ---------------------------------------------------------------------------
// aes_mixcolumns_iter
//   Iterative AES MixColumns stage. A 128-bit state (ShiftRows output,
//   column-major, byte 0 at [127:120]) is latched on an input handshake and
//   transformed in place, COLS_PER_CYCLE columns per clock, starting at
//   column 0. The result is held in DONE until the consumer takes it.
//   With in_bypass=1 the state is passed through untouched (final round).
//
// Parameters
//   COLS_PER_CYCLE : columns transformed per clock; 1, 2 or 4.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active high
//   in_valid   : in_state / in_bypass valid
//   in_ready   : block is idle and will take a state
//   in_state   : 128-bit input state
//   in_bypass  : skip MixColumns for this state
//   out_valid  : out_state holds a completed result
//   out_ready  : consumer takes out_state
//   out_state  : 128-bit result, same byte order as in_state
// ---------------------------------------------------------------------------

// One MixColumns column: bytes a0..a3 are rows 0..3, a0 in the MSBs.
module aes_mixcol_lane (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    always_comb begin
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end

    assign col_o = {b0, b1, b2, b3};
endmodule

module aes_mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);
    // Column groups are aligned to COLS_PER_CYCLE, so a column belongs to the
    // active group when its index and the counter agree above GRP_SHIFT.
    localparam int         GRP_SHIFT = (COLS_PER_CYCLE == 4) ? 2 :
                                       (COLS_PER_CYCLE == 2) ? 1 : 0;
    // STEP truncates to 0 for 4 columns: the counter never leaves 0 and the
    // single group is also the last one.
    localparam logic [1:0] STEP      = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL  = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;
    logic         byp_q, byp_d;

    logic [31:0]                         cols [4];
    logic [COLS_PER_CYCLE-1:0][31:0]     mix_in;
    logic [COLS_PER_CYCLE-1:0][31:0]     mix_out;
    logic [127:0]                        work_mixed;

    // Column view of the working register.
    for (genvar c = 0; c < 4; c++) begin : g_cols
        assign cols[c] = work_q[127-32*c -: 32];
    end

    // Feed the active group's columns into the lanes.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_sel
        logic [1:0] idx;
        assign idx       = col_q + 2'(g);
        assign mix_in[g] = cols[idx];
    end

    aes_mixcol_lane u_lane [COLS_PER_CYCLE-1:0] (
        .col_i (mix_in),
        .col_o (mix_out)
    );

    // Write transformed columns back in place; others are kept.
    for (genvar c = 0; c < 4; c++) begin : g_wb
        localparam int LANE = c & (COLS_PER_CYCLE - 1);
        logic hit;
        assign hit = ((2'(c) >> GRP_SHIFT) == (col_q >> GRP_SHIFT));
        assign work_mixed[127-32*c -: 32] = hit ? mix_out[LANE] : cols[c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            work_q  <= 128'd0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            byp_q   <= byp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        byp_d   = byp_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    byp_d   = in_bypass;
                    col_d   = 2'd0;
                    state_d = in_bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                work_d = work_mixed;
                col_d  = col_q + STEP;
                if (col_q == LAST_COL) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_state = work_q;
endmodule

// File: tb/tb_aes_mixcolumns_iter.sv
module tb_aes_mixcolumns_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_bypass [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] in_state  [3];
    logic [127:0] out_state [3];

    int n_chk  = 0;
    int n_fail = 0;
    int acc_cnt [3];
    int out_cnt [3];

    localparam logic [127:0] V1_IN  = 128'hdb135345f20a225c010101012d26314c;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc9fdc589d010101014d7ebdf8;
    localparam logic [127:0] V2_IN  = 128'hc6c6c6c6d4d4d4d5c6c6c6c6d4d4d4d5;
    localparam logic [127:0] V2_OUT = 128'hc6c6c6c6d5d5d7d6c6c6c6c6d5d5d7d6;
    localparam logic [127:0] BY_IN  = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mixcolumns_iter #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_bypass (in_bypass[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst && in_valid[k] && in_ready[k])   acc_cnt[k] <= acc_cnt[k] + 1;
            if (!rst && out_valid[k] && out_ready[k]) out_cnt[k] <= out_cnt[k] + 1;
        end
    end

    function automatic int cols_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    // Edges from acceptance (inclusive) until out_valid is seen.
    function automatic int exp_lat(input int k, input logic byp);
        return byp ? 1 : (4 / cols_of(k)) + 1;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] st);
        logic [7:0]   base [4];
        logic [127:0] r = 128'd0;
        logic [7:0]   acc;
        base[0] = 8'd2; base[1] = 8'd3; base[2] = 8'd1; base[3] = 8'd1;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(st[127-8*(4*c+j) -: 8], base[(j - row + 4) % 4]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Drives one state through DUT k; results are checked by the caller.
    task automatic xfer(input int k, input logic [127:0] st, input logic byp,
                        input int gap, input int stall,
                        output logic [127:0] res, output int lat,
                        output int waitn, output bit stable);
        out_ready[k] = 1'b0;
        in_valid[k]  = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_state[k]  = st;
        in_bypass[k] = byp;
        in_valid[k]  = 1'b1;
        waitn = 0;
        while (in_ready[k] !== 1'b1 && waitn < 50) begin
            @(negedge clk);
            waitn++;
        end
        @(posedge clk); #1;
        in_valid[k]  = 1'b0;
        in_state[k]  = ~st;
        in_bypass[k] = ~byp;
        lat = 1;
        while (out_valid[k] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_state[k];
        stable = 1'b1;
        repeat (stall) begin
            @(posedge clk); #1;
            if (out_state[k] !== res || out_valid[k] !== 1'b1) stable = 1'b0;
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (in_ready[k] !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready dut%0d got %b want 1", k, in_ready[k]);
            end
            n_chk++;
            if (out_valid[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid dut%0d got %b want 0", k, out_valid[k]);
            end
            n_chk++;
            if (out_state[k] !== 128'd0) begin
                n_fail++; $display("FAIL reset_out_state dut%0d got %h want 0", k, out_state[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_columns;
        logic [127:0] res; int lat, waitn; bit stable;
        xfer(0, V1_IN, 1'b0, 0, 0, res, lat, waitn, stable);
        n_chk++;
        if (res !== V1_OUT) begin
            n_fail++; $display("FAIL columns_data got %h want %h", res, V1_OUT);
        end
        n_chk++;
        if (lat !== 5) begin
            n_fail++; $display("FAIL columns_latency got %0d want 5", lat);
        end
        n_chk++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL columns_idle_after got %b want 1", in_ready[0]);
        end
    endtask

    task automatic test_param_sweep;
        logic [127:0] res; int lat, waitn; bit stable;
        for (int k = 0; k < 3; k++) begin
            xfer(k, V1_IN, 1'b0, 1, 0, res, lat, waitn, stable);
            n_chk++;
            if (res !== V1_OUT) begin
                n_fail++; $display("FAIL sweep_v1 dut%0d got %h want %h", k, res, V1_OUT);
            end
            n_chk++;
            if (lat !== exp_lat(k, 1'b0)) begin
                n_fail++; $display("FAIL sweep_latency dut%0d got %0d want %0d", k, lat, exp_lat(k, 1'b0));
            end
            xfer(k, V2_IN, 1'b0, 0, 0, res, lat, waitn, stable);
            n_chk++;
            if (res !== V2_OUT) begin
                n_fail++; $display("FAIL sweep_v2 dut%0d got %h want %h", k, res, V2_OUT);
            end
        end
    endtask

    task automatic test_bypass;
        logic [127:0] res; int lat, waitn; bit stable;
        for (int k = 0; k < 3; k++) begin
            xfer(k, BY_IN, 1'b1, 0, 0, res, lat, waitn, stable);
            n_chk++;
            if (res !== BY_IN) begin
                n_fail++; $display("FAIL bypass_data dut%0d got %h want %h", k, res, BY_IN);
            end
            n_chk++;
            if (lat !== 1) begin
                n_fail++; $display("FAIL bypass_latency dut%0d got %0d want 1", k, lat);
            end
        end
    endtask

    task automatic test_backpressure;
        int n;
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_state[0]  = V1_IN;
        in_bypass[0] = 1'b0;
        in_valid[0]  = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n = 0;
        while (out_valid[0] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++;
        if (out_valid[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_reach_done got %b want 1", out_valid[0]);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid[0]  = ~in_valid[0];
            in_state[0]  = {$urandom, $urandom, $urandom, $urandom};
            in_bypass[0] = i[0];
            @(posedge clk); #1;
            n_chk++;
            if (out_state[0] !== V1_OUT || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall cyc%0d got state %h valid %b ready %b want %h 1 0",
                         i, out_state[0], out_valid[0], in_ready[0], V1_OUT);
            end
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        n_chk++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got ready %b valid %b want 1 0", in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] res; int lat, waitn; bit stable;
        out_ready[0] = 1'b1;
        @(negedge clk);
        in_state[0]  = V1_IN;
        in_bypass[0] = 1'b0;
        in_valid[0]  = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (out_valid[0] !== 1'b0 || out_state[0] !== 128'd0 || in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_abort got valid %b state %h ready %b want 0 0 1",
                     out_valid[0], out_state[0], in_ready[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        xfer(0, V2_IN, 1'b0, 0, 0, res, lat, waitn, stable);
        n_chk++;
        if (res !== V2_OUT || lat !== 5) begin
            n_fail++; $display("FAIL midrst_recover got %h lat %0d want %h lat 5", res, lat, V2_OUT);
        end
        n_chk++;
        if (waitn !== 0) begin
            n_fail++; $display("FAIL midrst_first_accept got wait %0d want 0", waitn);
        end
    endtask

    task automatic test_random;
        logic [127:0] st, res, exp_s; int lat, waitn; bit stable; logic byp;
        int acc0 [3], out0 [3], nx [3];
        int bad = 0;
        for (int k = 0; k < 3; k++) begin
            acc0[k] = acc_cnt[k]; out0[k] = out_cnt[k]; nx[k] = 0;
        end
        for (int i = 0; i < 1000; i++) begin
            int k = i % 3;
            st  = {$urandom, $urandom, $urandom, $urandom};
            byp = ($urandom_range(0, 3) == 0);
            exp_s = byp ? st : mix_ref(st);
            xfer(k, st, byp, $urandom_range(0, 3), $urandom_range(0, 4), res, lat, waitn, stable);
            nx[k]++;
            n_chk++;
            if (res !== exp_s || lat !== exp_lat(k, byp) || !stable) begin
                n_fail++; bad++;
                if (bad < 10)
                    $display("FAIL random_%0d dut%0d got %h lat %0d stable %0d want %h lat %0d",
                             i, k, res, lat, stable, exp_s, exp_lat(k, byp));
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (acc_cnt[k] - acc0[k] !== nx[k] || out_cnt[k] - out0[k] !== nx[k]) begin
                n_fail++;
                $display("FAIL random_count dut%0d got in %0d out %0d want %0d",
                         k, acc_cnt[k] - acc0[k], out_cnt[k] - out0[k], nx[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_bypass[k] = 1'b0; out_ready[k] = 1'b0;
            in_state[k] = 128'd0; acc_cnt[k] = 0; out_cnt[k] = 0;
        end
        test_reset;
        test_columns;
        test_param_sweep;
        test_bypass;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
